// File: rtl/user_uart_tx.sv
// FIFO-buffered 8N1 UART transmitter with a valid/ready byte input and a per-frame baud divisor.
// Optional even parity bit: define USER_UART_TX_PARITY_EN (frame becomes 8E1).
module user_uart_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic [DIV_W-1:0] clkdiv,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             tx,
    output logic             busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef USER_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
    logic             fifo_empty, fifo_full, push, pop;
    logic [7:0]       head;
    logic [DIV_W-1:0] period_eff;

    state_t           state_reg, state_next;
    logic [7:0]       shift_reg, shift_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [DIV_W-1:0] timer_reg, timer_next;
    logic [DIV_W-1:0] period_reg, period_next;
    logic             tx_reg, tx_next;
`ifdef USER_UART_TX_PARITY_EN
    logic             parity_reg, parity_next;
`endif

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = ((wr_ptr_reg ^ rd_ptr_reg) == {1'b1, {AW{1'b0}}});
    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready;
    assign head       = mem[rd_ptr_reg[AW-1:0]];
    assign period_eff = (clkdiv == '0) ? DIV_W'(1) : clkdiv;

    // Storage is left unreset so it can map onto distributed/block RAM.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_idx_reg <= '0;
            timer_reg   <= '0;
            period_reg  <= '0;
            tx_reg      <= 1'b1;
`ifdef USER_UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_idx_reg <= bit_idx_next;
            timer_reg   <= timer_next;
            period_reg  <= period_next;
            tx_reg      <= tx_next;
`ifdef USER_UART_TX_PARITY_EN
            parity_reg  <= parity_next;
`endif
        end
    end

    // tx_next is the line level for the state being entered, so tx is a plain register.
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx_reg;
        timer_next   = timer_reg;
        period_next  = period_reg;
        tx_next      = tx_reg;
        pop          = 1'b0;
`ifdef USER_UART_TX_PARITY_EN
        parity_next  = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) pop = 1'b1;
            end
            START: begin
                if (timer_reg == '0) begin
                    state_next = DATA;
                    timer_next = period_reg - DIV_W'(1);
                    tx_next    = shift_reg[0];
                end else begin
                    timer_next = timer_reg - DIV_W'(1);
                end
            end
            DATA: begin
                if (timer_reg == '0) begin
                    timer_next = period_reg - DIV_W'(1);
                    if (bit_idx_reg == 3'd7) begin
`ifdef USER_UART_TX_PARITY_EN
                        state_next = PARITY;
                        tx_next    = parity_reg;
`else
                        state_next = STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        shift_next   = {1'b0, shift_reg[7:1]};
                        bit_idx_next = bit_idx_reg + 3'd1;
                        tx_next      = shift_reg[1];
                    end
                end else begin
                    timer_next = timer_reg - DIV_W'(1);
                end
            end
`ifdef USER_UART_TX_PARITY_EN
            PARITY: begin
                if (timer_reg == '0) begin
                    state_next = STOP;
                    timer_next = period_reg - DIV_W'(1);
                    tx_next    = 1'b1;
                end else begin
                    timer_next = timer_reg - DIV_W'(1);
                end
            end
`endif
            STOP: begin
                if (timer_reg == '0) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end else begin
                    timer_next = timer_reg - DIV_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase

        // Popping from IDLE or the end of STOP both launch a fresh frame.
        if (pop) begin
            state_next   = START;
            shift_next   = head;
            period_next  = period_eff;
            timer_next   = period_eff - DIV_W'(1);
            bit_idx_next = 3'd0;
            tx_next      = 1'b0;
`ifdef USER_UART_TX_PARITY_EN
            parity_next  = ^head;
`endif
        end
    end

    assign tx   = tx_reg;
    assign busy = (state_reg != IDLE) || !fifo_empty;

endmodule
